// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock on a single round datapath,
// with round keys fetched from an external schedule store through rk_idx.
module aes_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
    $error("aes_cipher_iter: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] st;
  logic [127:0] round_out;
  logic         last;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];

  assign last = (round == 4'(NR));

  // Byte i sits at bits [127-8i -: 8]; byte index = row + 4*column.
  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = SBOX[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    round_out = '0;
    for (int i = 0; i < 16; i++) round_out[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk_i[127-8*i -: 8];
  end

  // Round counter doubles as the key index; it is parked at 0 outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      round     <= 4'd0;
      st        <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st    <= in_state ^ rk_i;
            round <= 4'd1;
            busy  <= 1'b1;
            fsm   <= RUN;
          end
        end
        RUN: begin
          st <= round_out;
          if (last) begin
            round     <= 4'd0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              st    <= in_state ^ rk_i;
              round <= 4'd1;
              fsm   <= RUN;
            end else begin
              busy <= 1'b0;
              fsm  <= IDLE;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign rk_idx    = round;
  assign out_state = st;
  assign in_ready  = !rst && ((fsm == IDLE) || ((fsm == DONE) && out_ready));

endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative AES encryption core that runs a full cipher (initial AddRoundKey, NR−1 full rounds, final round) on one 128-bit block using a single round datapath reused once per clock. NR is parametrised for AES-128/192/256. Blocks are accepted and returned over ready/valid handshakes. Round keys come from an external key-schedule store addressed by a round-index output. The block sits between the block-mode/IO logic and the key-expansion RAM, replacing a fully unrolled round pipeline where area matters more than throughput.

## Interface
- NR, default 10: number of cipher rounds. Legal values are 10, 12 and 14; any other value is an elaboration-time `$error`.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input block available.
- in_ready  output  1  core can accept a block this cycle.
- in_state  input  128  plaintext; byte 0 is bits [127:120], column-major as in FIPS-197.
- rk_idx  output  4  round-key index requested this cycle, 0..NR.
- rk_i  input  128  round key for rk_idx; combinational, valid in the same cycle.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_state  output  128  ciphertext, same byte order as in_state.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Internal registers: 128-bit state register, 4-bit round counter.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid: load in_state ^ rk_i, set round=1, go to RUN.
- RUN:
  - rk_idx=round.
  - The state register is replaced by AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_i).
  - When round==NR, MixColumns is omitted (final round) and the FSM goes to DONE. Otherwise round increments.
- DONE:
  - out_valid=1, out_state=state register, rk_idx=0.
  - out_state holds stable while out_valid=1 and out_ready=0.
  - On out_ready with in_valid=0: go to IDLE.
  - On out_ready with in_valid=1 (back-to-back): the new block is accepted in the same cycle. The register loads in_state ^ rk_i, round=1, and the FSM goes to RUN.
- in_ready = IDLE | (DONE & out_ready). in_ready is combinational from out_ready; this is the only in/out combinational path.
- Handshake rules:
  - A transfer happens on an edge where valid & ready are both high.
  - in_state is sampled only on the accepting edge. in_valid/in_state changes during RUN are ignored.
  - out_valid never drops without a completed handshake, except on reset.
- Datapath arithmetic:
  - S-box is the FIPS-197 forward table, 16 parallel lookups.
  - MixColumns is over GF(2^8) with xtime reduction polynomial 0x11b.
  - All XORs are 128-bit and bytewise; no carries.
- Reset (rst=1 on an edge, including mid-RUN or mid-DONE):
  - FSM=IDLE, round=0, state register=0.
  - out_valid=0, out_state=0, busy=0, rk_idx=0.
  - in_ready=0 while rst is high; 1 on the first cycle after rst deasserts.
  - An in-flight block is discarded and no output is produced for it.

## Timing
- Acceptance edge T (IDLE or DONE). The round datapath updates on edges T+1..T+NR.
- out_valid is high from the cycle after edge T+NR. Latency from acceptance to out_valid is NR+1 cycles: 11 for NR=10, 13 for NR=12, 15 for NR=14.
- rk_idx sequence from acceptance: 0, 1, 2, …, NR. Each value is held for exactly one cycle; no gaps or repeats while out_ready is high.
- Sustained throughput with out_ready=1 and in_valid=1: one block per NR+1 cycles.
- With out_ready=0, the core stalls in DONE indefinitely, holding rk_idx=0.

## Test plan
- NR=10: key 000102…0f, in_state 00112233445566778899aabbccddeeff, with the bench supplying expanded keys by rk_idx.
  - out_state must be 69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid must rise exactly 11 cycles after acceptance.
  - The rk_idx trace must be 0..10.
- NR=12 with key 000102…17, and NR=14 with key 000102…1f, same plaintext:
  - NR=12 → dda97ca4864cdfe06eaf70a0ec0d7191, latency 13.
  - NR=14 → 8ea2b7ca516745bfeafc49904b496089, latency 15.
- Back-to-back, NR=10: three blocks presented continuously with out_ready=1.
  - Outputs appear at 11-cycle spacing, each matching the reference model.
  - in_ready is high in each DONE cycle.
- Backpressure: out_ready held low for 5 cycles after out_valid.
  - out_state is stable, in_ready=0, and in_valid/in_state toggling has no effect.
  - Releasing out_ready completes exactly one transfer.
- Reset mid-RUN: assert rst at round 5 of a block.
  - Next cycle: out_valid=0, out_state=0, rk_idx=0, busy=0.
  - A fresh block then encrypts correctly with no residue from the aborted one.
- Random regression: 1000 random keys and plaintexts per NR value, with random in_valid/out_ready gaps.
  - Every output matches the software AES model.
  - No block is dropped or duplicated.
